// File: rtl/spi_controller.sv
// spi_controller: mode-0 SPI initiator, 16-bit {rw, addr[6:0], data[7:0]} frames, MSB first.
// Optional read support (cmd_rw/cipo/rdata/rvalid) when SPI_CTRL_READ_EN is defined. Rev 1.0
`default_nettype none

module spi_controller #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
`ifdef SPI_CTRL_READ_EN
  input  logic       cmd_rw,
  input  logic       cipo,
  output logic [7:0] rdata,
  output logic       rvalid,
`endif
  output logic       busy,
  output logic       done,
  output logic       ncs,
  output logic       sclk,
  output logic       copi
);

  localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TMAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE)
                                             : ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [DW-1:0] C_DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [TW-1:0] C_SETUP_LAST = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0] C_HOLD_LAST  = TW'(CS_HOLD - 1);
  localparam logic [TW-1:0] C_IDLE_LAST  = TW'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t        r_state;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;
  logic          r_ncs;
  logic          r_sclk;
  logic          r_copi;
  logic [14:0]   r_shift;
  logic [DW-1:0] r_div;
  logic [TW-1:0] r_tcnt;
  logic [4:0]    r_bitcnt;
  logic          w_rw;

`ifdef SPI_CTRL_READ_EN
  logic       r_rw;
  logic [7:0] r_rx;
  logic [7:0] r_rdata;
  logic       r_rvalid;
  assign w_rw   = cmd_rw;
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
`else
  assign w_rw   = 1'b1;
`endif

  // Ready is held low for the whole reset cycle so an overlapping cmd_valid is never seen as accepted.
  assign cmd_ready = r_ready & ~rst;
  assign busy      = r_busy;
  assign done      = r_done;
  assign ncs       = r_ncs;
  assign sclk      = r_sclk;
  assign copi      = r_copi;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ncs    <= 1'b1;
      r_sclk   <= 1'b0;
      r_copi   <= 1'b0;
      r_shift  <= '0;
      r_div    <= '0;
      r_tcnt   <= '0;
      r_bitcnt <= '0;
`ifdef SPI_CTRL_READ_EN
      r_rw     <= 1'b1;
      r_rx     <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef SPI_CTRL_READ_EN
      r_rvalid <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_ready) begin
            r_shift <= {cmd_addr, cmd_data};
            r_copi  <= w_rw;
            r_ncs   <= 1'b0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_tcnt  <= '0;
            r_state <= S_SETUP;
`ifdef SPI_CTRL_READ_EN
            r_rw    <= cmd_rw;
`endif
          end
        end
        S_SETUP: begin
          if (r_tcnt == C_SETUP_LAST) begin
            r_tcnt   <= '0;
            r_div    <= '0;
            r_bitcnt <= '0;
            r_state  <= S_SHIFT;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_SHIFT: begin
`ifdef SPI_CTRL_READ_EN
          if (r_sclk && r_div == '0) r_rx <= {r_rx[6:0], cipo};
`endif
          if (r_div == C_DIV_LAST) begin
            r_div <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              // Falling edge: next bit goes out in the same cycle so it is settled long before the next rise.
              r_sclk   <= 1'b0;
              r_bitcnt <= r_bitcnt + 5'd1;
              if (r_bitcnt == 5'd15) begin
                r_copi  <= 1'b0;
                r_tcnt  <= '0;
                r_state <= S_HOLD;
              end else begin
                r_copi  <= r_shift[14];
                r_shift <= r_shift << 1;
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_HOLD: begin
          if (r_tcnt == C_HOLD_LAST) begin
            r_ncs   <= 1'b1;
            r_done  <= 1'b1;
            r_tcnt  <= '0;
            r_state <= S_GAP;
`ifdef SPI_CTRL_READ_EN
            if (!r_rw) begin
              r_rdata  <= r_rx;
              r_rvalid <= 1'b1;
            end
`endif
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_tcnt == C_IDLE_LAST) begin
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_controller.sv
// tb_spi_controller: scoreboard bench for spi_controller; frames are rebuilt from copi at sclk rises.
// Define SPI_CTRL_READ_EN to also exercise the read path. Rev 1.0
`default_nettype none

module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       busy, done, ncs, sclk, copi;
`ifdef SPI_CTRL_READ_EN
  logic       cmd_rw = 1'b1;
  logic       cipo;
  logic [7:0] rdata;
  logic       rvalid;
  logic [15:0] tx_word = 16'h005A;
`endif

  typedef struct packed {
    logic [15:0] frame;
    logic        rd;
    logic [7:0]  rdat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  int errors = 0;
  int checks = 0;

  int   edges = 0, fall_cnt = 0, low_cnt = 0, high_cnt = 0, last_gap = 0, since_rise = 0;
  int   done_cnt = 0;
  bit   abort = 0, track_ready = 0;
  logic prev_sclk = 1'b0, prev_ncs = 1'b1, prev_ready = 1'b0;
  logic [15:0] rx_frame = '0;

  spi_controller dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
`ifdef SPI_CTRL_READ_EN
    .cmd_rw    (cmd_rw),
    .cipo      (cipo),
    .rdata     (rdata),
    .rvalid    (rvalid),
`endif
    .busy      (busy),
    .done      (done),
    .ncs       (ncs),
    .sclk      (sclk),
    .copi      (copi)
  );

  always #5 clk = ~clk;

`ifdef SPI_CTRL_READ_EN
  // Target model: presents a new bit after each sclk fall, MSB first.
  assign cipo = (fall_cnt < 16) ? tx_word[4'(15 - fall_cnt)] : 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (ncs) begin
      check("sclk_low_while_ncs_high", {31'd0, sclk}, 32'd0);
      high_cnt++;
    end else begin
      low_cnt++;
      if (!prev_sclk && sclk) begin
        rx_frame = {rx_frame[14:0], copi};
        edges++;
      end
      if (prev_sclk && !sclk) fall_cnt++;
    end
    if (prev_ncs && !ncs) begin
      last_gap = high_cnt;
      low_cnt  = 1;
      edges    = 0;
      fall_cnt = 0;
      rx_frame = '0;
    end
    if (!prev_ncs && ncs) begin
      high_cnt   = 1;
      since_rise = 0;
      if (abort) begin
        abort       = 0;
        track_ready = 0;
        check("abort_no_done", {31'd0, done}, 32'd0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
        track_ready = 1;
        check("done_at_ncs_rise", {31'd0, done}, 32'd1);
        check("ncs_low_cycles", low_cnt, 136);
        check("sclk_rise_count", edges, 16);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", {16'd0, rx_frame}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("frame_bits", {16'd0, rx_frame}, {16'd0, e.frame});
`ifdef SPI_CTRL_READ_EN
          check("rvalid", {31'd0, rvalid}, {31'd0, e.rd});
          if (e.rd) check("rdata", {24'd0, rdata}, {24'd0, e.rdat});
`endif
        end
      end
    end else if (ncs) begin
      since_rise++;
    end
    if (track_ready && cmd_ready && !prev_ready) begin
      check("ready_after_ncs_rise", since_rise, 4);
      track_ready = 0;
    end
    prev_sclk  = sclk;
    prev_ncs   = ncs;
    prev_ready = cmd_ready;
  end

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic [6:0] a, input logic [7:0] d, input logic rw, input bit keep);
    exp_t x;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
`ifdef SPI_CTRL_READ_EN
    cmd_rw = rw;
`endif
    wait_ready();
    x.frame = {rw, a, d};
    x.rd    = ~rw;
    x.rdat  = 8'h5A;
    exp_q.push_back(x);
    @(negedge clk);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("ready_low_when_busy", {31'd0, cmd_ready}, 32'd0);
    check("ncs_falls_after_accept", {31'd0, ncs}, 32'd0);
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int frames;
    frames    = 0;
    // Reset with a simultaneous request: reset must win.
    cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ncs", {31'd0, ncs}, 32'd1);
    check("rst_sclk", {31'd0, sclk}, 32'd0);
    check("rst_copi", {31'd0, copi}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    issue(7'h00, 8'hA5, 1'b1, 1'b0);
    wait_idle();
    frames++;

    // Back-to-back with cmd_valid held; second command is presented while busy.
    issue(7'h02, 8'hFF, 1'b1, 1'b1);
    issue(7'h03, 8'h0F, 1'b1, 1'b0);
    @(negedge clk);
    check("b2b_ncs_high_gap", last_gap, 5);
    wait_idle();
    frames += 2;

    // Inputs changing after acceptance must not reach the frame.
    issue(7'h10, 8'h55, 1'b1, 1'b0);
    cmd_data = 8'hAA;
    cmd_addr = 7'h7F;
    wait_idle();
    frames++;

    // Reset during the 7th sclk high phase.
    issue(7'h20, 8'h99, 1'b1, 1'b0);
    n = 0;
    while (edges < 7 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (edges < 7) check("edge_wait_timeout", 32'd0, 32'd1);
    abort = 1;
    rst   = 1'b1;
    @(negedge clk);
    check("abort_ncs", {31'd0, ncs}, 32'd1);
    check("abort_sclk", {31'd0, sclk}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'd0, cmd_ready}, 32'd1);

    issue(7'h21, 8'h3C, 1'b1, 1'b0);
    wait_idle();
    frames++;

`ifdef SPI_CTRL_READ_EN
    issue(7'h05, 8'h00, 1'b0, 1'b0);
    wait_idle();
    frames++;
    check("rdata_hold", {24'd0, rdata}, 32'h5A);
`endif

    repeat (8) @(negedge clk);
    check("done_pulse_count", done_cnt, frames);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
